datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have these ports, clock and reset first; the reset is rst_ctrl, asynchronous, active-high, and the clock is clk_ctrl.
- clk_ctrl      in   1  clock; all state updates on its rising edge.
- rst_ctrl      in   1  asynchronous active-high reset.
- muxsel_dp     in   2  accumulator-input source select.
- imm_dp        in   8  immediate operand; reserved, ignored by this block.
- input_dp      in   8  external input port value.
- accwr_dp      in   1  accumulator write enable.
- rfaddr_dp     in   3  register-file address, for both read and write.
- rfwr_dp       in   1  register-file write enable.
- mmadr_dp      in   4  data-memory address, for both read and write.
- mmwr_dp       in   1  data-memory write enable.
- alusel_dp     in   3  ALU operation select.
- shiftsel_dp   in   2  shifter operation select.
- outen_dp      in   1  output-register load enable.
- zero_dp       out  1  accumulator-equals-zero flag.
- positive_dp   out  1  accumulator-positive flag.
- output_dp     out  8  output port register.

Function
REQ-002 The block SHALL hold an 8-bit accumulator A, an 8x8 register file RF, a 16x8 data memory MEM and an 8-bit output register OUT.
REQ-003 RF[rfaddr_dp] and MEM[mmadr_dp] SHALL be read combinationally; B denotes RF[rfaddr_dp].
REQ-004 The ALU SHALL compute, in 8 bits with wrap-around and no carry out, per alusel_dp:
- 000: A
- 001: A+B
- 010: A-B
- 011: A AND B
- 100: A OR B
- 101: NOT A
- 110: A+1
- 111: A-1
REQ-005 The shifter SHALL take the ALU result R and produce, per shiftsel_dp:
- 00: R
- 01: R shifted left, 0 into bit 0
- 10: R shifted right logically, 0 into bit 7
- 11: R rotated right, bit 0 into bit 7
REQ-006 The accumulator-input mux SHALL select, per muxsel_dp: 00 shifter output; 01 B; 10 input_dp; 11 MEM[mmadr_dp].
REQ-007 On a rising clk_ctrl edge with accwr_dp=1, A SHALL load the mux output; otherwise A SHALL hold.
REQ-008 On a rising edge with rfwr_dp=1, RF[rfaddr_dp] SHALL load the pre-edge value of A.
REQ-009 On a rising edge with mmwr_dp=1, MEM[mmadr_dp] SHALL load the pre-edge value of A.
REQ-010 On a rising edge with outen_dp=1, OUT SHALL load the pre-edge value of A; otherwise OUT SHALL hold.
REQ-011 output_dp SHALL equal OUT.
REQ-012 When writes coincide in one edge (any combination of accwr_dp, rfwr_dp, mmwr_dp, outen_dp), every destination SHALL take the old A; reads SHALL return old contents.
REQ-013 zero_dp SHALL be combinational and equal 1 exactly when A==8'h00.
REQ-014 positive_dp SHALL be combinational and equal 1 exactly when A[7]==0 and A!=0.
REQ-015 Latency SHALL be one clock from enable to register update; flags SHALL reflect the new A within the same cycle as the update.

Reset
REQ-016 While rst_ctrl=1, A, every RF entry, every MEM entry and OUT SHALL be 8'h00, independent of the clock, so output_dp=0, zero_dp=1 and positive_dp=0.
REQ-017 Assertion of rst_ctrl mid-operation SHALL override any pending write in that cycle.

Structure
REQ-018 Package datapath_pkg SHALL contain the muxsel, alusel and shiftsel code constants as enumerated typedefs.
REQ-019 Sub-module datapath_alu SHALL implement the combinational ALU and shifter (REQ-004, REQ-005); storage, mux and flags SHALL reside in datapath.

Verification
REQ-020 Reset, then muxsel=10, input_dp=8'h05, accwr=1 for one edge -> A=05, zero_dp=0, positive_dp=1.
REQ-021 With A=05: rfwr=1, rfaddr=3 for one edge; then input_dp=8'h03 loaded into A; then alusel=001, rfaddr=3, accwr=1 -> A=08. Repeat with alusel=010 -> A=03.
REQ-022 With A=8'h81: shiftsel=11 -> A=C0; shiftsel=01 from A=81 -> A=02; shiftsel=10 from A=81 -> A=40.
REQ-023 With A=8'hFF: alusel=110 -> A=00 and zero_dp=1. From A=00: alusel=111 -> A=FF, positive_dp=0, zero_dp=0.
REQ-024 With A=8'h3C: mmwr=1, mmadr=9; then A loaded with 0; then muxsel=11, mmadr=9, accwr=1 -> A=3C. Then outen=1 for one edge -> output_dp=3C, which holds after outen drops.
REQ-025 Assert rst_ctrl asynchronously mid-clock-period with accwr=1 -> A, output_dp, RF[3] and MEM[9] all read 00 immediately and after release.

Source files
------------

// File: rtl/datapath_pkg.sv
// ============================================================
// Package : datapath_pkg
// Purpose : widths, depths and select codes shared by the datapath
// Rev     : 1.0
// ============================================================
`default_nettype none

package datapath_pkg;

    localparam int DATA_W    = 8;
    localparam int RF_DEPTH  = 8;
    localparam int MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        MUX_SHIFT = 2'b00,
        MUX_RF    = 2'b01,
        MUX_INPUT = 2'b10,
        MUX_MEM   = 2'b11
    } mux_sel_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_AND  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_NOT  = 3'b101,
        ALU_INC  = 3'b110,
        ALU_DEC  = 3'b111
    } alu_sel_e;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SHL  = 2'b01,
        SH_SHR  = 2'b10,
        SH_ROR  = 2'b11
    } shift_sel_e;

endpackage

`default_nettype wire

// File: rtl/datapath_alu.sv
// ============================================================
// Module  : datapath_alu
// Purpose : combinational ALU followed by the shifter stage
// Rev     : 1.0
// ============================================================
`default_nettype none

module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_sel_e          alusel_i,
    input  shift_sel_e        shiftsel_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] w_alu;

    always_comb begin
        w_alu = a_i;
        unique case (alusel_i)
            ALU_PASS: w_alu = a_i;
            ALU_ADD:  w_alu = a_i + b_i;
            ALU_SUB:  w_alu = a_i - b_i;
            ALU_AND:  w_alu = a_i & b_i;
            ALU_OR:   w_alu = a_i | b_i;
            ALU_NOT:  w_alu = ~a_i;
            ALU_INC:  w_alu = a_i + 8'd1;
            ALU_DEC:  w_alu = a_i - 8'd1;
        endcase
    end

    always_comb begin
        result_o = w_alu;
        unique case (shiftsel_i)
            SH_PASS: result_o = w_alu;
            SH_SHL:  result_o = {w_alu[DATA_W-2:0], 1'b0};
            SH_SHR:  result_o = {1'b0, w_alu[DATA_W-1:1]};
            SH_ROR:  result_o = {w_alu[0], w_alu[DATA_W-1:1]};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/datapath.sv
// ============================================================
// Module  : datapath
// Purpose : accumulator, register file, data memory and output register
// Rev     : 1.0
// ============================================================
`default_nettype none

module datapath
    import datapath_pkg::*;
(
    input  logic        clk_ctrl,
    input  logic        rst_ctrl,
    input  logic [1:0]  muxsel_dp,
    input  logic [7:0]  imm_dp,
    input  logic [7:0]  input_dp,
    input  logic        accwr_dp,
    input  logic [2:0]  rfaddr_dp,
    input  logic        rfwr_dp,
    input  logic [3:0]  mmadr_dp,
    input  logic        mmwr_dp,
    input  logic [2:0]  alusel_dp,
    input  logic [1:0]  shiftsel_dp,
    input  logic        outen_dp,
    output logic        zero_dp,
    output logic        positive_dp,
    output logic [7:0]  output_dp
);

    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] rf_q  [RF_DEPTH];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_mem_rd;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_mux;
    logic              w_unused_imm;

    assign w_unused_imm = ^imm_dp;

    assign w_b      = rf_q[rfaddr_dp];
    assign w_mem_rd = mem_q[mmadr_dp];

    datapath_alu u_alu (
        .a_i        (acc_q),
        .b_i        (w_b),
        .alusel_i   (alu_sel_e'(alusel_dp)),
        .shiftsel_i (shift_sel_e'(shiftsel_dp)),
        .result_o   (w_shift)
    );

    always_comb begin
        w_mux = w_shift;
        unique case (mux_sel_e'(muxsel_dp))
            MUX_SHIFT: w_mux = w_shift;
            MUX_RF:    w_mux = w_b;
            MUX_INPUT: w_mux = input_dp;
            MUX_MEM:   w_mux = w_mem_rd;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (accwr_dp) begin
            acc_d = w_mux;
        end
    end

    // Every write port samples acc_q, so coincident writes all see the old A.
    always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
        if (rst_ctrl) begin
            acc_q <= '0;
            out_q <= '0;
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            if (outen_dp) begin
                out_q <= acc_q;
            end
            if (rfwr_dp) begin
                rf_q[rfaddr_dp] <= acc_q;
            end
            if (mmwr_dp) begin
                mem_q[mmadr_dp] <= acc_q;
            end
        end
    end

    assign output_dp   = out_q;
    assign zero_dp     = (acc_q == '0);
    assign positive_dp = ~acc_q[DATA_W-1] & (acc_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================
// Module  : tb_datapath
// Purpose : directed vector table plus randomized run against a reference model
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_datapath;

    logic       clk_ctrl = 1'b0;
    logic       rst_ctrl = 1'b1;
    logic [1:0] muxsel_dp = '0;
    logic [7:0] imm_dp = '0;
    logic [7:0] input_dp = '0;
    logic       accwr_dp = 1'b0;
    logic [2:0] rfaddr_dp = '0;
    logic       rfwr_dp = 1'b0;
    logic [3:0] mmadr_dp = '0;
    logic       mmwr_dp = 1'b0;
    logic [2:0] alusel_dp = '0;
    logic [1:0] shiftsel_dp = '0;
    logic       outen_dp = 1'b0;
    logic       zero_dp;
    logic       positive_dp;
    logic [7:0] output_dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk_ctrl = ~clk_ctrl;

    datapath dut (
        .clk_ctrl    (clk_ctrl),
        .rst_ctrl    (rst_ctrl),
        .muxsel_dp   (muxsel_dp),
        .imm_dp      (imm_dp),
        .input_dp    (input_dp),
        .accwr_dp    (accwr_dp),
        .rfaddr_dp   (rfaddr_dp),
        .rfwr_dp     (rfwr_dp),
        .mmadr_dp    (mmadr_dp),
        .mmwr_dp     (mmwr_dp),
        .alusel_dp   (alusel_dp),
        .shiftsel_dp (shiftsel_dp),
        .outen_dp    (outen_dp),
        .zero_dp     (zero_dp),
        .positive_dp (positive_dp),
        .output_dp   (output_dp)
    );

    typedef struct {
        logic [1:0] mux;
        logic [7:0] inp;
        logic       accwr;
        logic [2:0] ra;
        logic       rfwr;
        logic [3:0] ma;
        logic       mmwr;
        logic [2:0] alu;
        logic [1:0] sh;
        logic       outen;
        logic [7:0] exp_a;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int mux, int inp, int accwr, int ra, int rfwr, int ma,
                                int mmwr, int alu, int sh, int outen, int exp_a);
        vec_t v;
        v.mux = 2'(mux);   v.inp = 8'(inp);   v.accwr = 1'(accwr);
        v.ra = 3'(ra);     v.rfwr = 1'(rfwr); v.ma = 4'(ma);
        v.mmwr = 1'(mmwr); v.alu = 3'(alu);   v.sh = 2'(sh);
        v.outen = 1'(outen); v.exp_a = 8'(exp_a);
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flags(string name, int a);
        chk({name, "_zero"}, int'(zero_dp), (a == 0) ? 1 : 0);
        chk({name, "_pos"}, int'(positive_dp), (a != 0 && a < 128) ? 1 : 0);
    endtask

    task automatic idle_inputs();
        muxsel_dp = '0; input_dp = '0; accwr_dp = 1'b0; rfaddr_dp = '0; rfwr_dp = 1'b0;
        mmadr_dp = '0; mmwr_dp = 1'b0; alusel_dp = '0; shiftsel_dp = '0; outen_dp = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    // Reference model: architectural state held as plain arrays
    int m_a, m_out;
    int m_rf[8];
    int m_mem[16];

    function automatic int ref_alu(int a, int b, int sel);
        case (sel)
            0: return a;
            1: return (a + b) % 256;
            2: return (a + 256 - b) % 256;
            3: return a & b;
            4: return a | b;
            5: return 255 - a;
            6: return (a + 1) % 256;
            default: return (a + 255) % 256;
        endcase
    endfunction

    function automatic int ref_shift(int r, int sel);
        case (sel)
            0: return r;
            1: return (r * 2) % 256;
            2: return r / 2;
            default: return r / 2 + (r % 2) * 128;
        endcase
    endfunction

    task automatic model_clear();
        m_a = 0; m_out = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
    endtask

    task automatic model_step();
        int b, src, old_a;
        old_a = m_a;
        b = m_rf[rfaddr_dp];
        case (muxsel_dp)
            2'd0: src = ref_shift(ref_alu(old_a, b, int'(alusel_dp)), int'(shiftsel_dp));
            2'd1: src = b;
            2'd2: src = int'(input_dp);
            default: src = m_mem[mmadr_dp];
        endcase
        if (accwr_dp) m_a = src;
        if (rfwr_dp)  m_rf[rfaddr_dp] = old_a;
        if (mmwr_dp)  m_mem[mmadr_dp] = old_a;
        if (outen_dp) m_out = old_a;
    endtask

    initial begin
        int exp_out;
        int prev_a;

        // Reset state, held across clock edges
        #2;
        chk("rst_out", int'(output_dp), 0);
        chk_flags("rst", 0);
        tick();
        tick();
        chk("rst_out_clk", int'(output_dp), 0);
        chk_flags("rst_clk", 0);
        rst_ctrl = 1'b0;

        // Directed vectors
        tbl.push_back(mk(2, 'h05, 1, 0, 0, 0, 0, 0, 0, 0, 'h05));
        tbl.push_back(mk(0, 'h00, 0, 3, 1, 0, 0, 0, 0, 0, 'h05));
        tbl.push_back(mk(2, 'h03, 1, 0, 0, 0, 0, 0, 0, 0, 'h03));
        tbl.push_back(mk(0, 'h00, 1, 3, 0, 0, 0, 1, 0, 0, 'h08));
        tbl.push_back(mk(0, 'h00, 1, 3, 0, 0, 0, 2, 0, 0, 'h03));
        tbl.push_back(mk(2, 'h81, 1, 0, 0, 0, 0, 0, 0, 0, 'h81));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 0, 3, 0, 'hC0));
        tbl.push_back(mk(2, 'h81, 1, 0, 0, 0, 0, 0, 0, 0, 'h81));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 0, 1, 0, 'h02));
        tbl.push_back(mk(2, 'h81, 1, 0, 0, 0, 0, 0, 0, 0, 'h81));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 0, 2, 0, 'h40));
        tbl.push_back(mk(2, 'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 'hFF));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 6, 0, 0, 'h00));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 7, 0, 0, 'hFF));
        tbl.push_back(mk(2, 'h3C, 1, 0, 0, 0, 0, 0, 0, 0, 'h3C));
        tbl.push_back(mk(0, 'h00, 0, 0, 0, 9, 1, 0, 0, 0, 'h3C));
        tbl.push_back(mk(2, 'h00, 1, 0, 0, 0, 0, 0, 0, 0, 'h00));
        tbl.push_back(mk(3, 'h00, 1, 0, 0, 9, 0, 0, 0, 0, 'h3C));
        tbl.push_back(mk(1, 'h00, 1, 3, 0, 0, 0, 0, 0, 0, 'h05));
        tbl.push_back(mk(2, 'h77, 1, 5, 1, 2, 1, 0, 0, 1, 'h77));
        tbl.push_back(mk(1, 'h00, 1, 5, 0, 0, 0, 0, 0, 0, 'h05));
        tbl.push_back(mk(3, 'h00, 1, 0, 0, 2, 0, 0, 0, 0, 'h05));
        tbl.push_back(mk(2, 'hA5, 1, 0, 0, 0, 0, 0, 0, 0, 'hA5));
        tbl.push_back(mk(0, 'h00, 1, 3, 0, 0, 0, 3, 0, 0, 'h05));
        tbl.push_back(mk(2, 'hA0, 1, 0, 0, 0, 0, 0, 0, 0, 'hA0));
        tbl.push_back(mk(0, 'h00, 1, 3, 0, 0, 0, 4, 0, 0, 'hA5));
        tbl.push_back(mk(0, 'h00, 1, 0, 0, 0, 0, 5, 0, 0, 'h5A));

        // A is observed through OUT: each row is followed by an outen-only edge
        exp_out = 0;
        prev_a  = 0;
        foreach (tbl[i]) begin
            muxsel_dp = tbl[i].mux;  input_dp = tbl[i].inp;  accwr_dp = tbl[i].accwr;
            rfaddr_dp = tbl[i].ra;   rfwr_dp = tbl[i].rfwr;  mmadr_dp = tbl[i].ma;
            mmwr_dp = tbl[i].mmwr;   alusel_dp = tbl[i].alu; shiftsel_dp = tbl[i].sh;
            outen_dp = tbl[i].outen;
            imm_dp = 8'($urandom);
            tick();
            if (tbl[i].outen) exp_out = prev_a;
            chk($sformatf("vec%0d_out", i), int'(output_dp), exp_out);
            chk_flags($sformatf("vec%0d", i), int'(tbl[i].exp_a));
            idle_inputs();
            outen_dp = 1'b1;
            tick();
            chk($sformatf("vec%0d_a", i), int'(output_dp), int'(tbl[i].exp_a));
            exp_out = int'(tbl[i].exp_a);
            prev_a  = int'(tbl[i].exp_a);
        end

        // OUT holds once outen drops while A changes
        idle_inputs();
        muxsel_dp = 2'd2; input_dp = 8'h11; accwr_dp = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("out_hold", int'(output_dp), 'h5A);
        chk_flags("out_hold", 'h11);

        // Asynchronous reset mid-period, overriding a pending accumulator write
        muxsel_dp = 2'd2; input_dp = 8'hAA; accwr_dp = 1'b1; outen_dp = 1'b1;
        #3;
        rst_ctrl = 1'b1;
        #1;
        chk("arst_out", int'(output_dp), 0);
        chk_flags("arst", 0);
        tick();
        chk("arst_out_edge", int'(output_dp), 0);
        chk_flags("arst_edge", 0);
        rst_ctrl = 1'b0;
        idle_inputs();
        muxsel_dp = 2'd2; input_dp = 8'h55; accwr_dp = 1'b1;
        tick();
        chk_flags("post_rst_load", 'h55);
        muxsel_dp = 2'd1; rfaddr_dp = 3'd3;
        tick();
        chk_flags("post_rst_rf3", 0);
        muxsel_dp = 2'd2; input_dp = 8'h55;
        tick();
        muxsel_dp = 2'd3; mmadr_dp = 4'd9;
        tick();
        chk_flags("post_rst_mem9", 0);
        chk("post_rst_out", int'(output_dp), 0);

        // Randomized run against the reference model from a clean reset
        idle_inputs();
        rst_ctrl = 1'b1;
        tick();
        rst_ctrl = 1'b0;
        model_clear();
        for (int n = 0; n < 400; n++) begin
            muxsel_dp   = 2'($urandom);
            imm_dp      = 8'($urandom);
            input_dp    = 8'($urandom);
            accwr_dp    = ($urandom_range(0, 3) != 0);
            rfaddr_dp   = 3'($urandom);
            rfwr_dp     = ($urandom_range(0, 2) == 0);
            mmadr_dp    = 4'($urandom);
            mmwr_dp     = ($urandom_range(0, 2) == 0);
            alusel_dp   = 3'($urandom);
            shiftsel_dp = 2'($urandom);
            outen_dp    = ($urandom_range(0, 1) == 0);
            model_step();
            tick();
            chk($sformatf("rnd%0d_out", n), int'(output_dp), m_out);
            chk_flags($sformatf("rnd%0d", n), m_a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
